// File: rtl/top_div_pkg.sv
`default_nettype none
// ============================================================================
// Module   : top_div_pkg
// Brief    : Shared widths, FSM encoding and helpers for the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
package top_div_pkg;

    localparam int N_DEF = 62;
    localparam int M_DEF = 32;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_CALC = CALC,
        ST_DONE = DONE
    } state_t;

    // Enough bits to hold an iteration index of 0..n-1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int CNT_W = cnt_width(N_DEF);

endpackage
`default_nettype wire

// File: rtl/top_udiv_62ns_32ns_seq_if.sv
`default_nettype none
// ============================================================================
// Module   : top_udiv_62ns_32ns_seq_if
// Brief    : Operand/result valid-ready bundle of the sequential divider.
// Revision : 1.0  initial release
// ============================================================================
interface top_udiv_62ns_32ns_seq_if
    import top_div_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int M = M_DEF
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] din0;
    logic [M-1:0] din1;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quot;
    logic [M-1:0] rem;
    logic         div_zero;

    modport master (
        output in_valid, din0, din1, out_ready,
        input  in_ready, out_valid, quot, rem, div_zero
    );

    modport slave (
        input  in_valid, din0, din1, out_ready,
        output in_ready, out_valid, quot, rem, div_zero
    );
endinterface
`default_nettype wire

// File: rtl/top_udiv_62ns_32ns_step.sv
`default_nettype none
// ============================================================================
// Module   : top_udiv_62ns_32ns_step
// Brief    : One radix-2 restoring division step (compare/subtract, M+1 bits).
// Revision : 1.0  initial release
// ============================================================================
module top_udiv_62ns_32ns_step
    import top_div_pkg::*;
#(
    parameter int M = M_DEF
) (
    input  wire logic [M-1:0] i_r,
    input  wire logic         i_bit,
    input  wire logic [M-1:0] i_divisor,
    output logic      [M-1:0] o_r_next,
    output logic              o_qbit
);
    logic [M:0] w_trial;

    assign w_trial = {i_r, i_bit};
    assign o_qbit  = (w_trial >= {1'b0, i_divisor});
    // Difference is below the divisor, so the low M bits carry it exactly.
    assign o_r_next = o_qbit ? (w_trial[M-1:0] - i_divisor) : w_trial[M-1:0];

endmodule
`default_nettype wire

// File: rtl/top_udiv_62ns_32ns_seq.sv
`default_nettype none
// ============================================================================
// Module   : top_udiv_62ns_32ns_seq
// Brief    : Iterative unsigned N/M divider, one quotient bit per cycle.
// Revision : 1.0  initial release
// ============================================================================
module top_udiv_62ns_32ns_seq
    import top_div_pkg::*;
#(
    parameter int ID         = 1,
    parameter int din0_WIDTH = N_DEF,
    parameter int din1_WIDTH = M_DEF
) (
    input  wire logic               ap_clk,
    input  wire logic               ap_rst,
    top_udiv_62ns_32ns_seq_if.slave s_if
);
    localparam int N  = din0_WIDTH;
    localparam int M  = din1_WIDTH;
    localparam int CW = cnt_width(N);
    localparam logic [CW-1:0] c_CNT_START = CW'(N - 1);
    localparam logic [CW-1:0] c_CNT_ONE   = CW'(1);

    // ID is an instance tag only and shapes no hardware.
    if (ID < 0) begin : g_id_tag
    end

    state_t        r_state_q,     w_state_d;
    logic          r_in_ready_q,  w_in_ready_d;
    logic          r_out_valid_q, w_out_valid_d;
    logic          r_div_zero_q,  w_div_zero_d;
    logic [N-1:0]  r_dividend_q,  w_dividend_d;
    logic [M-1:0]  r_divisor_q,   w_divisor_d;
    logic [N-1:0]  r_quot_q,      w_quot_d;
    logic [M-1:0]  r_rem_q,       w_rem_d;
    logic [CW-1:0] r_cnt_q,       w_cnt_d;

    logic [M-1:0]  w_step_rem;
    logic          w_step_qbit;

    top_udiv_62ns_32ns_step #(
        .M (M)
    ) u_step (
        .i_r       (r_rem_q),
        .i_bit     (r_dividend_q[r_cnt_q]),
        .i_divisor (r_divisor_q),
        .o_r_next  (w_step_rem),
        .o_qbit    (w_step_qbit)
    );

    always_comb begin
        w_state_d     = r_state_q;
        w_in_ready_d  = r_in_ready_q;
        w_out_valid_d = r_out_valid_q;
        w_div_zero_d  = r_div_zero_q;
        w_dividend_d  = r_dividend_q;
        w_divisor_d   = r_divisor_q;
        w_quot_d      = r_quot_q;
        w_rem_d       = r_rem_q;
        w_cnt_d       = r_cnt_q;
        case (r_state_q)
            ST_IDLE: begin
                if (s_if.in_valid) begin
                    w_in_ready_d = 1'b0;
                    if (s_if.din1 != '0) begin
                        w_dividend_d = s_if.din0;
                        w_divisor_d  = s_if.din1;
                        w_rem_d      = '0;
                        w_quot_d     = '0;
                        w_div_zero_d = 1'b0;
                        w_cnt_d      = c_CNT_START;
                        w_state_d    = ST_CALC;
                    end else begin
                        w_quot_d      = '1;
                        w_rem_d       = s_if.din0[M-1:0];
                        w_div_zero_d  = 1'b1;
                        w_out_valid_d = 1'b1;
                        w_state_d     = ST_DONE;
                    end
                end
            end
            ST_CALC: begin
                // Shifting in after N steps lands each bit at q[count].
                w_rem_d  = w_step_rem;
                w_quot_d = {r_quot_q[N-2:0], w_step_qbit};
                if (r_cnt_q == '0) begin
                    w_out_valid_d = 1'b1;
                    w_state_d     = ST_DONE;
                end else begin
                    w_cnt_d = r_cnt_q - c_CNT_ONE;
                end
            end
            ST_DONE: begin
                if (s_if.out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_in_ready_d  = 1'b1;
                    w_state_d     = ST_IDLE;
                end
            end
            default: begin
                w_out_valid_d = 1'b0;
                w_in_ready_d  = 1'b1;
                w_state_d     = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state_q     <= ST_IDLE;
            r_in_ready_q  <= 1'b1;
            r_out_valid_q <= 1'b0;
            r_div_zero_q  <= 1'b0;
            r_dividend_q  <= '0;
            r_divisor_q   <= '0;
            r_quot_q      <= '0;
            r_rem_q       <= '0;
            r_cnt_q       <= '0;
        end else begin
            r_state_q     <= w_state_d;
            r_in_ready_q  <= w_in_ready_d;
            r_out_valid_q <= w_out_valid_d;
            r_div_zero_q  <= w_div_zero_d;
            r_dividend_q  <= w_dividend_d;
            r_divisor_q   <= w_divisor_d;
            r_quot_q      <= w_quot_d;
            r_rem_q       <= w_rem_d;
            r_cnt_q       <= w_cnt_d;
        end
    end

    assign s_if.in_ready  = r_in_ready_q;
    assign s_if.out_valid = r_out_valid_q;
    assign s_if.quot      = r_quot_q;
    assign s_if.rem       = r_rem_q;
    assign s_if.div_zero  = r_div_zero_q;

endmodule
`default_nettype wire

// File: tb/tb_top_udiv_62ns_32ns_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_top_udiv_62ns_32ns_seq
// Brief    : Self-checking bench for the sequential 62/32 divider.
// Revision : 1.0  initial release
// ============================================================================
module tb_top_udiv_62ns_32ns_seq;
    localparam int N = 62;
    localparam int M = 32;
    localparam logic [N-1:0] c_ONES = 62'h3FFF_FFFF_FFFF_FFFF;

    typedef struct {
        logic [N-1:0] quot;
        logic [M-1:0] rem;
        logic         dz;
    } exp_t;

    typedef struct {
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [N-1:0] quot;
        logic [M-1:0] rem;
        logic         dz;
        int           lat;
    } vec_t;

    logic  clk = 1'b0;
    logic  rst = 1'b1;
    int    checks = 0;
    int    errors = 0;
    string cur_tag = "init";
    exp_t  exp_q[$];

    always #5 clk = ~clk;

    top_udiv_62ns_32ns_seq_if #(.N(N), .M(M)) u_if ();

    top_udiv_62ns_32ns_seq #(
        .ID         (1),
        .din0_WIDTH (N),
        .din1_WIDTH (M)
    ) u_dut (
        .ap_clk (clk),
        .ap_rst (rst),
        .s_if   (u_if)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s/%s actual=%0h required=%0h", cur_tag, nm, act, req);
        end
    endtask

    function automatic exp_t model(input logic [N-1:0] a, input logic [M-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.quot = c_ONES;
            e.rem  = a[M-1:0];
            e.dz   = 1'b1;
        end else begin
            e.quot = a / N'(b);
            e.rem  = M'(a % N'(b));
            e.dz   = 1'b0;
        end
        return e;
    endfunction

    // Result monitor: a result is consumed on the edge after out_valid & out_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && u_if.out_valid && u_if.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL %s/unexpected_result actual quot=%0h rem=%0h required none",
                             cur_tag, u_if.quot, u_if.rem);
                end else begin
                    e = exp_q.pop_front();
                    chk("quot", 64'(u_if.quot), 64'(e.quot));
                    chk("rem", 64'(u_if.rem), 64'(e.rem));
                    chk("div_zero", 64'(u_if.div_zero), 64'(e.dz));
                end
            end
        end
    end

    // Called #1 after a rising edge; returns #1 after the handshake edge.
    task automatic send(input logic [N-1:0] a, input logic [M-1:0] b, input exp_t e);
        int g = 0;
        u_if.in_valid = 1'b1;
        u_if.din0     = a;
        u_if.din1     = b;
        @(negedge clk);
        while (!u_if.in_ready && g < 200) begin
            @(negedge clk);
            g++;
        end
        chk("in_ready_wait", 64'(u_if.in_ready), 64'd1);
        if (u_if.in_ready) exp_q.push_back(e);
        @(posedge clk);
        #1;
        u_if.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 1;
        while (!u_if.out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic wait_release();
        int g = 0;
        while (u_if.out_valid && g < 200) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk("release", 64'(u_if.out_valid), 64'd0);
    endtask

    task automatic run_one(input logic [N-1:0] a, input logic [M-1:0] b, input exp_t e,
                           input int exp_lat);
        int lat;
        send(a, b, e);
        wait_valid(lat);
        chk("latency", 64'(lat), 64'(exp_lat));
        wait_release();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t         vecs[11];
        exp_t         e;
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [63:0]  rnd;
        int           lat;

        vecs[0]  = '{62'd100, 32'd7, 62'd14, 32'd2, 1'b0, 63};
        vecs[1]  = '{c_ONES, 32'd1, c_ONES, 32'd0, 1'b0, 63};
        vecs[2]  = '{c_ONES, 32'hFFFF_FFFF, 62'h4000_0000, 32'h3FFF_FFFF, 1'b0, 63};
        vecs[3]  = '{62'd5, 32'hFFFF_FFFF, 62'd0, 32'd5, 1'b0, 63};
        vecs[4]  = '{62'd0, 32'd9, 62'd0, 32'd0, 1'b0, 63};
        vecs[5]  = '{62'd1234, 32'd0, c_ONES, 32'd1234, 1'b1, 1};
        vecs[6]  = '{62'd0, 32'd0, c_ONES, 32'd0, 1'b1, 1};
        vecs[7]  = '{62'h0123_4567_89AB_CDEF, 32'd0, c_ONES, 32'h89AB_CDEF, 1'b1, 1};
        vecs[8]  = '{62'hFFFF_FFFF, 32'hFFFF_FFFF, 62'd1, 32'd0, 1'b0, 63};
        vecs[9]  = '{62'h1_0000_0000, 32'h8000_0000, 62'd2, 32'd0, 1'b0, 63};
        vecs[10] = '{62'd1000000007, 32'd13, 62'd76923077, 32'd6, 1'b0, 63};

        u_if.in_valid  = 1'b0;
        u_if.din0      = '0;
        u_if.din1      = '0;
        u_if.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        cur_tag = "reset_state";
        chk("in_ready", 64'(u_if.in_ready), 64'd1);
        chk("out_valid", 64'(u_if.out_valid), 64'd0);
        chk("quot", 64'(u_if.quot), 64'd0);
        chk("rem", 64'(u_if.rem), 64'd0);
        chk("div_zero", 64'(u_if.div_zero), 64'd0);

        foreach (vecs[i]) begin
            cur_tag = $sformatf("vec%0d", i);
            e = '{vecs[i].quot, vecs[i].rem, vecs[i].dz};
            run_one(vecs[i].a, vecs[i].b, e, vecs[i].lat);
        end

        // Back-pressure in DONE with an in_valid pulse that must be ignored.
        cur_tag = "hold";
        u_if.out_ready = 1'b0;
        send(62'd100, 32'd7, '{62'd14, 32'd2, 1'b0});
        wait_valid(lat);
        chk("latency", 64'(lat), 64'd63);
        for (int k = 0; k < 5; k++) begin
            u_if.in_valid = (k == 2);
            u_if.din0     = 62'd999;
            u_if.din1     = 32'd3;
            @(negedge clk);
            chk("quot", 64'(u_if.quot), 64'd14);
            chk("rem", 64'(u_if.rem), 64'd2);
            chk("div_zero", 64'(u_if.div_zero), 64'd0);
            chk("out_valid", 64'(u_if.out_valid), 64'd1);
            chk("in_ready", 64'(u_if.in_ready), 64'd0);
            @(posedge clk);
            #1;
        end
        u_if.in_valid  = 1'b0;
        u_if.out_ready = 1'b1;
        wait_release();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("idle_out_valid", 64'(u_if.out_valid), 64'd0);
            chk("idle_in_ready", 64'(u_if.in_ready), 64'd1);
        end
        @(posedge clk);
        #1;

        // Reset in the middle of CALC drops the division without a result.
        cur_tag = "abort";
        send(62'd100, 32'd7, '{62'd14, 32'd2, 1'b0});
        repeat (19) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        chk("in_ready", 64'(u_if.in_ready), 64'd1);
        chk("out_valid", 64'(u_if.out_valid), 64'd0);
        chk("quot", 64'(u_if.quot), 64'd0);
        chk("rem", 64'(u_if.rem), 64'd0);
        cur_tag = "after_abort";
        run_one(62'd100, 32'd7, '{62'd14, 32'd2, 1'b0}, 63);

        for (int i = 0; i < 300; i++) begin
            cur_tag = $sformatf("rand%0d", i);
            rnd = {$urandom, $urandom};
            a   = rnd[N-1:0];
            b   = $urandom;
            case ($urandom_range(0, 9))
                0:       b = '0;
                1:       b = M'($urandom_range(1, 15));
                2:       a = a >> $urandom_range(30, 61);
                3:       b = 32'hFFFF_FFFF;
                default: ;
            endcase
            run_one(a, b, model(a, b), (b == '0) ? 1 : 63);
        end

        cur_tag = "final";
        repeat (5) @(posedge clk);
        #1;
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
